// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: ALU one-hot bit positions, multiply op codes,
// multiplier FSM encodings, bus widths and the decode->execute payload.
package exe_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ALU_W  = 13;
  localparam int unsigned MOP_W  = 2;
  localparam int unsigned MEMC_W = 4;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned SHAMT_W = 5;

  localparam int unsigned ALU_OVF  = 12;
  localparam int unsigned ALU_ADD  = 11;
  localparam int unsigned ALU_SUB  = 10;
  localparam int unsigned ALU_SLT  = 9;
  localparam int unsigned ALU_SLTU = 8;
  localparam int unsigned ALU_AND  = 7;
  localparam int unsigned ALU_NOR  = 6;
  localparam int unsigned ALU_OR   = 5;
  localparam int unsigned ALU_XOR  = 4;
  localparam int unsigned ALU_SLL  = 3;
  localparam int unsigned ALU_SRL  = 2;
  localparam int unsigned ALU_SRA  = 1;
  localparam int unsigned ALU_LUI  = 0;

  localparam logic [MOP_W-1:0] MOP_NONE  = 2'b00;
  localparam logic [MOP_W-1:0] MOP_MULT  = 2'b01;
  localparam logic [MOP_W-1:0] MOP_MULTU = 2'b10;

  localparam logic [1:0] MUL_IDLE = 2'b00;
  localparam logic [1:0] MUL_BUSY = 2'b01;
  localparam logic [1:0] MUL_DONE = 2'b10;

  typedef struct packed {
    logic [ALU_W-1:0]  alu_control;
    logic [XLEN-1:0]   src1;
    logic [XLEN-1:0]   src2;
    logic [MOP_W-1:0]  mult_op;
    logic [MEMC_W-1:0] mem_control;
    logic [XLEN-1:0]   store_data;
    logic [REG_W-1:0]  rf_wdest;
    logic [XLEN-1:0]   pc;
  } id_bus_t;

  // Encoding 11 is illegal and behaves as "no multiply".
  function automatic logic is_mult(input logic [MOP_W-1:0] op);
    return (op == MOP_MULT) || (op == MOP_MULTU);
  endfunction

endpackage

// File: rtl/exe_stage_alu.sv
// One-hot ALU: add/sub/slt/sltu/logic/shifts/lui with optional signed-overflow detection.
// Shifts take the amount from src1[4:0] and shift src2.
module alu
  import exe_stage_pkg::*;
(
  input  logic [ALU_W-1:0] ctrl_i,
  input  logic [XLEN-1:0]  src1_i,
  input  logic [XLEN-1:0]  src2_i,
  output logic [XLEN-1:0]  result_o,
  output logic             ovf_o
);

  logic [XLEN-1:0]    sum;
  logic [XLEN-1:0]    diff;
  logic [SHAMT_W-1:0] shamt;
  logic               slt;
  logic               sltu;
  logic               add_ovf;
  logic               sub_ovf;

  assign sum   = src1_i + src2_i;
  assign diff  = src1_i - src2_i;
  assign shamt = src1_i[SHAMT_W-1:0];
  assign slt   = $signed(src1_i) < $signed(src2_i);
  assign sltu  = src1_i < src2_i;

  // Signed overflow: result sign disagrees with the operand signs that agree.
  assign add_ovf = (src1_i[XLEN-1] == src2_i[XLEN-1]) && (sum[XLEN-1]  != src1_i[XLEN-1]);
  assign sub_ovf = (src1_i[XLEN-1] != src2_i[XLEN-1]) && (diff[XLEN-1] != src1_i[XLEN-1]);
  assign ovf_o   = ctrl_i[ALU_OVF] & ((ctrl_i[ALU_ADD] & add_ovf) | (ctrl_i[ALU_SUB] & sub_ovf));

  always_comb begin
    result_o = '0;
    if (ctrl_i[ALU_ADD])  result_o = result_o | sum;
    if (ctrl_i[ALU_SUB])  result_o = result_o | diff;
    if (ctrl_i[ALU_SLT])  result_o = result_o | {{(XLEN-1){1'b0}}, slt};
    if (ctrl_i[ALU_SLTU]) result_o = result_o | {{(XLEN-1){1'b0}}, sltu};
    if (ctrl_i[ALU_AND])  result_o = result_o | (src1_i & src2_i);
    if (ctrl_i[ALU_NOR])  result_o = result_o | ~(src1_i | src2_i);
    if (ctrl_i[ALU_OR])   result_o = result_o | (src1_i | src2_i);
    if (ctrl_i[ALU_XOR])  result_o = result_o | (src1_i ^ src2_i);
    if (ctrl_i[ALU_SLL])  result_o = result_o | (src2_i << shamt);
    if (ctrl_i[ALU_SRL])  result_o = result_o | (src2_i >> shamt);
    if (ctrl_i[ALU_SRA])  result_o = result_o | XLEN'($signed(src2_i) >>> shamt);
    if (ctrl_i[ALU_LUI])  result_o = result_o | {src2_i[15:0], 16'h0000};
  end

endmodule

// File: rtl/exe_stage_mul_iter.sv
// Iterative shift-add 32x32 multiplier (signed via magnitudes + sign fix-up) with an
// IDLE/BUSY/DONE FSM; HI/LO are registered and hilo_we pulses once per finished product.
module mul_iter
  import exe_stage_pkg::*;
#(
  parameter int unsigned MUL_BITS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic            cancel_i,
  input  logic            drain_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic            done_o,
  output logic            hilo_we_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  localparam int unsigned STEPS  = XLEN / MUL_BITS;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned PROD_W = 2 * XLEN;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [PROD_W-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic              neg_q, neg_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;

  logic [PROD_W-1:0] step_sum;
  logic [PROD_W-1:0] acc_next;
  logic [PROD_W-1:0] prod_final;
  logic [XLEN-1:0]   mag1;
  logic [XLEN-1:0]   mag2;

  // abs(-2^31) wraps to 0x80000000, which is the correct unsigned magnitude.
  assign mag1 = (signed_i && src1_i[XLEN-1]) ? XLEN'(-src1_i) : src1_i;
  assign mag2 = (signed_i && src2_i[XLEN-1]) ? XLEN'(-src2_i) : src2_i;

  always_comb begin
    step_sum = '0;
    for (int unsigned i = 0; i < MUL_BITS; i++) begin
      if (mplier_q[i]) step_sum = step_sum + (mcand_q << i);
    end
  end

  assign acc_next   = acc_q + step_sum;
  assign prod_final = neg_q ? PROD_W'(-acc_next) : acc_next;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    we_d     = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      MUL_BUSY: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << MUL_BITS;
        mplier_d = mplier_q >> MUL_BITS;
        if (cnt_q == '0) begin
          state_d = MUL_DONE;
          hi_d    = prod_final[PROD_W-1:XLEN];
          lo_d    = prod_final[XLEN-1:0];
          we_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MUL_DONE: begin
        if (drain_i) state_d = MUL_IDLE;
      end
      default: state_d = MUL_IDLE;
    endcase
    // A new multiply may start from IDLE or replace a draining DONE.
    if (start_i) begin
      state_d  = MUL_BUSY;
      cnt_d    = CNT_W'(STEPS - 1);
      acc_d    = '0;
      mcand_d  = {{XLEN{1'b0}}, mag1};
      mplier_d = mag2;
      neg_d    = signed_i & (src1_i[XLEN-1] ^ src2_i[XLEN-1]);
    end
    if (cancel_i) begin
      state_d = MUL_IDLE;
      we_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MUL_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      we_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      we_q     <= we_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign done_o    = (state_q == MUL_DONE);
  assign hilo_we_o = we_q;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;

endmodule

// File: rtl/exe_stage.sv
// Execute pipeline stage: registers the decode bus, runs the ALU or the iterative multiplier,
// and hands results to the memory stage over a valid/allowin handshake.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int unsigned MUL_BITS = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cancel,
  input  logic              id_valid,
  output logic              exe_allowin,
  input  logic [ALU_W-1:0]  id_alu_control,
  input  logic [XLEN-1:0]   id_alu_src1,
  input  logic [XLEN-1:0]   id_alu_src2,
  input  logic [MOP_W-1:0]  id_mult_op,
  input  logic [MEMC_W-1:0] id_mem_control,
  input  logic [XLEN-1:0]   id_store_data,
  input  logic [REG_W-1:0]  id_rf_wdest,
  input  logic [XLEN-1:0]   id_pc,
  input  logic              mem_allowin,
  output logic              exe_over,
  output logic [XLEN-1:0]   exe_result,
  output logic [MEMC_W-1:0] exe_mem_control,
  output logic [XLEN-1:0]   exe_store_data,
  output logic [REG_W-1:0]  exe_rf_wdest,
  output logic [XLEN-1:0]   exe_pc,
  output logic              exe_ovf_ex,
  output logic              exe_hilo_we,
  output logic [XLEN-1:0]   exe_hi,
  output logic [XLEN-1:0]   exe_lo
);

  logic    valid_q, valid_d;
  id_bus_t bus_q, bus_d;

  logic            load;
  logic            drain;
  logic            mult_q;
  logic            mul_done;
  logic            mul_we;
  logic [XLEN-1:0] alu_result;
  logic            alu_ovf;

  assign mult_q      = is_mult(bus_q.mult_op);
  assign exe_over    = valid_q & (~mult_q | mul_done);
  assign exe_allowin = ~valid_q | (exe_over & mem_allowin);
  assign load        = id_valid & exe_allowin & ~cancel;
  assign drain       = exe_over & mem_allowin;

  // Cancel wins over both load and drain; a simultaneous incoming instruction is dropped.
  always_comb begin
    valid_d = valid_q;
    bus_d   = bus_q;
    if (cancel) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d           = 1'b1;
      bus_d.alu_control = id_alu_control;
      bus_d.src1        = id_alu_src1;
      bus_d.src2        = id_alu_src2;
      bus_d.mult_op     = id_mult_op;
      bus_d.mem_control = id_mem_control;
      bus_d.store_data  = id_store_data;
      bus_d.rf_wdest    = id_rf_wdest;
      bus_d.pc          = id_pc;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      bus_q   <= '0;
    end else begin
      valid_q <= valid_d;
      bus_q   <= bus_d;
    end
  end

  alu u_alu (
    .ctrl_i   (bus_q.alu_control),
    .src1_i   (bus_q.src1),
    .src2_i   (bus_q.src2),
    .result_o (alu_result),
    .ovf_o    (alu_ovf)
  );

  mul_iter #(.MUL_BITS(MUL_BITS)) u_mul (
    .clk       (clk),
    .rst_n     (resetn),
    .start_i   (load & is_mult(id_mult_op)),
    .signed_i  (id_mult_op == MOP_MULT),
    .cancel_i  (cancel),
    .drain_i   (drain),
    .src1_i    (id_alu_src1),
    .src2_i    (id_alu_src2),
    .done_o    (mul_done),
    .hilo_we_o (mul_we),
    .hi_o      (exe_hi),
    .lo_o      (exe_lo)
  );

  assign exe_result      = mult_q ? '0 : alu_result;
  assign exe_ovf_ex      = valid_q & ~mult_q & alu_ovf;
  assign exe_rf_wdest    = exe_ovf_ex ? '0 : bus_q.rf_wdest;
  assign exe_mem_control = bus_q.mem_control;
  assign exe_store_data  = bus_q.store_data;
  assign exe_pc          = bus_q.pc;
  assign exe_hilo_we     = mul_we & ~cancel;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed and randomized ALU/multiply traffic checked against a
// plain-arithmetic reference; a second instance runs with two multiplier bits per cycle.
module tb_exe_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, cancel, id_valid, id_valid2, mem_allowin;
  logic [12:0] id_alu_control;
  logic [31:0] id_alu_src1, id_alu_src2, id_store_data, id_pc;
  logic [1:0]  id_mult_op;
  logic [3:0]  id_mem_control;
  logic [4:0]  id_rf_wdest;

  logic        allowin1, over1, ovf1, we1, allowin2, over2, ovf2, we2;
  logic [31:0] result1, sd1, pc1, hi1, lo1, result2, sd2, pc2, hi2, lo2;
  logic [3:0]  memc1, memc2;
  logic [4:0]  wd1, wd2;

  exe_stage #(.MUL_BITS(1)) u_dut (
    .clk(clk), .resetn(resetn), .cancel(cancel), .id_valid(id_valid), .exe_allowin(allowin1),
    .id_alu_control(id_alu_control), .id_alu_src1(id_alu_src1), .id_alu_src2(id_alu_src2),
    .id_mult_op(id_mult_op), .id_mem_control(id_mem_control), .id_store_data(id_store_data),
    .id_rf_wdest(id_rf_wdest), .id_pc(id_pc), .mem_allowin(mem_allowin), .exe_over(over1),
    .exe_result(result1), .exe_mem_control(memc1), .exe_store_data(sd1), .exe_rf_wdest(wd1),
    .exe_pc(pc1), .exe_ovf_ex(ovf1), .exe_hilo_we(we1), .exe_hi(hi1), .exe_lo(lo1)
  );

  exe_stage #(.MUL_BITS(2)) u_dut2 (
    .clk(clk), .resetn(resetn), .cancel(cancel), .id_valid(id_valid2), .exe_allowin(allowin2),
    .id_alu_control(id_alu_control), .id_alu_src1(id_alu_src1), .id_alu_src2(id_alu_src2),
    .id_mult_op(id_mult_op), .id_mem_control(id_mem_control), .id_store_data(id_store_data),
    .id_rf_wdest(id_rf_wdest), .id_pc(id_pc), .mem_allowin(mem_allowin), .exe_over(over2),
    .exe_result(result2), .exe_mem_control(memc2), .exe_store_data(sd2), .exe_rf_wdest(wd2),
    .exe_pc(pc2), .exe_ovf_ex(ovf2), .exe_hilo_we(we2), .exe_hi(hi2), .exe_lo(lo2)
  );

  bit          sel2 = 1'b0;
  logic        t_allowin, t_over, t_ovf, t_we;
  logic [31:0] t_result, t_sd, t_pc, t_hi, t_lo;
  logic [3:0]  t_memc;
  logic [4:0]  t_wd;
  assign t_allowin = sel2 ? allowin2 : allowin1;
  assign t_over    = sel2 ? over2 : over1;
  assign t_ovf     = sel2 ? ovf2 : ovf1;
  assign t_we      = sel2 ? we2 : we1;
  assign t_result  = sel2 ? result2 : result1;
  assign t_sd      = sel2 ? sd2 : sd1;
  assign t_pc      = sel2 ? pc2 : pc1;
  assign t_hi      = sel2 ? hi2 : hi1;
  assign t_lo      = sel2 ? lo2 : lo1;
  assign t_memc    = sel2 ? memc2 : memc1;
  assign t_wd      = sel2 ? wd2 : wd1;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_hi1 = '0, exp_lo1 = '0, exp_hi2 = '0, exp_lo2 = '0;

  // Reference ALU from the instruction-set definitions, using wide signed arithmetic.
  function automatic void alu_ref(input logic [12:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic o);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0;
    o = 1'b0;
    s = 0;
    if (c[11]) s = sa + sb;
    if (c[10]) s = sa - sb;
    if (c[11] || c[10]) begin
      r = 32'(s);
      o = c[12] && (s > longint'(32'sh7FFFFFFF) || s < longint'(32'sh80000000));
    end
    if (c[9]) r = (sa < sb) ? 32'd1 : 32'd0;
    if (c[8]) r = (a < b) ? 32'd1 : 32'd0;
    if (c[7]) r = a & b;
    if (c[6]) r = ~(a | b);
    if (c[5]) r = a | b;
    if (c[4]) r = a ^ b;
    if (c[3]) r = b << a[4:0];
    if (c[2]) r = b >> a[4:0];
    if (c[1]) r = 32'($signed(b) >>> a[4:0]);
    if (c[0]) r = {b[15:0], 16'h0000};
  endfunction

  function automatic logic [63:0] mul_ref(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    if (sgn) return 64'(longint'($signed(a)) * longint'($signed(b)));
    return {32'h0, a} * {32'h0, b};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 4))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      2: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Issue one instruction on an idle stage, hold it for `stall` cycles after completion, then drain.
  task automatic run_op(input string name, input bit use2, input logic [12:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] mop, input logic [4:0] wd, input int stall);
    logic [31:0] er, sd, pc, ehi, elo;
    logic        eo, ism;
    logic [63:0] ep;
    logic [3:0]  mc;
    int          k, lat;
    mc = 4'($urandom); sd = $urandom; pc = $urandom;
    ism = (mop == 2'b01) || (mop == 2'b10);
    er = '0; eo = 1'b0; ep = '0;
    if (ism) ep = mul_ref(mop == 2'b01, a, b);
    else alu_ref(c, a, b, er, eo);
    ehi = ism ? ep[63:32] : (use2 ? exp_hi2 : exp_hi1);
    elo = ism ? ep[31:0]  : (use2 ? exp_lo2 : exp_lo1);
    lat = ism ? (use2 ? 17 : 33) : 1;
    sel2 = use2;
    @(negedge clk);
    checks++;
    if (t_allowin !== 1'b1) begin errors++; $display("FAIL %s idle_allowin: got %b expected 1", name, t_allowin); end
    id_alu_control = c; id_alu_src1 = a; id_alu_src2 = b; id_mult_op = mop;
    id_mem_control = mc; id_store_data = sd; id_rf_wdest = wd; id_pc = pc;
    mem_allowin = (stall == 0);
    if (use2) id_valid2 = 1'b1; else id_valid = 1'b1;
    @(posedge clk);
    #1 id_valid = 1'b0; id_valid2 = 1'b0;
    k = 0;
    while (1) begin
      @(negedge clk);
      k++;
      if (t_over === 1'b1 || k >= 100) break;
    end
    checks++;
    if (t_over !== 1'b1 || k != lat) begin
      errors++; $display("FAIL %s latency: got %0d cycles (over=%b) expected %0d", name, k, t_over, lat);
    end
    checks++;
    if (t_result !== er || t_ovf !== eo || t_wd !== (eo ? 5'd0 : wd)) begin
      errors++;
      $display("FAIL %s result: got res=%h ovf=%b wdest=%0d expected res=%h ovf=%b wdest=%0d",
               name, t_result, t_ovf, t_wd, er, eo, eo ? 5'd0 : wd);
    end
    checks++;
    if (t_memc !== mc || t_sd !== sd || t_pc !== pc) begin
      errors++; $display("FAIL %s passthru: got %h/%h/%h expected %h/%h/%h", name, t_memc, t_sd, t_pc, mc, sd, pc);
    end
    checks++;
    if (t_we !== ism || t_hi !== ehi || t_lo !== elo) begin
      errors++; $display("FAIL %s hilo: got we=%b hi=%h lo=%h expected we=%b hi=%h lo=%h",
                         name, t_we, t_hi, t_lo, ism, ehi, elo);
    end
    if (use2) begin exp_hi2 = ehi; exp_lo2 = elo; end
    else begin exp_hi1 = ehi; exp_lo1 = elo; end
    if (stall > 0) begin
      checks++;
      if (t_allowin !== 1'b0) begin errors++; $display("FAIL %s stall_allowin: got %b expected 0", name, t_allowin); end
    end
    for (int s = 1; s < stall; s++) begin
      @(negedge clk);
      checks++;
      if (t_over !== 1'b1 || t_allowin !== 1'b0 || t_result !== er || t_we !== 1'b0 ||
          t_hi !== ehi || t_lo !== elo || t_pc !== pc) begin
        errors++; $display("FAIL %s hold: got over=%b allowin=%b res=%h we=%b hi=%h expected 1 0 %h 0 %h",
                           name, t_over, t_allowin, t_result, t_we, t_hi, er, ehi);
      end
    end
    mem_allowin = 1'b1;
    @(negedge clk);
    checks++;
    if (t_over !== 1'b0 || t_allowin !== 1'b1) begin
      errors++; $display("FAIL %s drain: got over=%b allowin=%b expected 0 1", name, t_over, t_allowin);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; cancel = 1'b0; id_valid = 1'b0; id_valid2 = 1'b0; mem_allowin = 1'b1;
    id_alu_control = '0; id_alu_src1 = '0; id_alu_src2 = '0; id_mult_op = '0;
    id_mem_control = '0; id_store_data = '0; id_rf_wdest = '0; id_pc = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (allowin1 !== 1'b1 || over1 !== 1'b0 || allowin2 !== 1'b1 || over2 !== 1'b0) begin
      errors++; $display("FAIL reset_handshake: got allowin=%b over=%b expected 1 0", allowin1, over1);
    end
    checks++;
    if (result1 !== '0 || wd1 !== '0 || pc1 !== '0 || sd1 !== '0 || memc1 !== '0 || ovf1 !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got res=%h wd=%0d pc=%h expected zeros", result1, wd1, pc1);
    end
    checks++;
    if (we1 !== 1'b0 || hi1 !== '0 || lo1 !== '0) begin
      errors++; $display("FAIL reset_hilo: got we=%b hi=%h lo=%h expected 0", we1, hi1, lo1);
    end
  endtask

  task automatic test_alu_directed();
    run_op("add_ovf", 0, 13'h1800, 32'h7FFFFFFF, 32'h1, 2'b00, 5'd5, 0);
    run_op("sra_stall", 0, 13'h0002, 32'h4, 32'hF0000000, 2'b00, 5'd7, 3);
    run_op("sub_ovf", 0, 13'h1400, 32'h80000000, 32'h1, 2'b00, 5'd9, 0);
    run_op("add_noovf", 0, 13'h0800, 32'h7FFFFFFF, 32'h1, 2'b00, 5'd3, 0);
    run_op("mop11_as_alu", 0, 13'h0020, 32'h0F0F0000, 32'h000000F0, 2'b11, 5'd4, 1);
    run_op("lui", 0, 13'h0001, 32'h0, 32'hABCD1234, 2'b00, 5'd8, 0);
  endtask

  task automatic test_alu_random();
    logic [12:0] c;
    int idx;
    for (int i = 0; i < 40; i++) begin
      idx = $urandom_range(0, 11);
      c = 13'(1) << idx;
      if ((idx == 11 || idx == 10) && $urandom_range(0, 1) == 1) c[12] = 1'b1;
      run_op("alu_rand", 0, c, pick_operand(), pick_operand(), 2'b00, 5'($urandom), $urandom_range(0, 2));
    end
  endtask

  task automatic test_mult();
    run_op("mult_neg", 0, 13'h0, 32'hFFFFFFFE, 32'd3, 2'b01, 5'd0, 0);
    run_op("mult_min_min", 0, 13'h0, 32'h80000000, 32'h80000000, 2'b01, 5'd0, 2);
    run_op("mult_min_one", 0, 13'h0, 32'h80000000, 32'h1, 2'b01, 5'd0, 0);
    for (int i = 0; i < 5; i++)
      run_op("mult_rand", 0, 13'($urandom), pick_operand(), pick_operand(),
             ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10, 5'($urandom), $urandom_range(0, 3));
  endtask

  task automatic test_mult_2bits();
    run_op("multu_x2", 1, 13'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 5'd0, 0);
    run_op("mult_x2_neg", 1, 13'h0, 32'h80000000, 32'h7FFFFFFF, 2'b01, 5'd0, 2);
    for (int i = 0; i < 4; i++)
      run_op("mul_x2_rand", 1, 13'h0, pick_operand(), pick_operand(),
             ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10, 5'd0, $urandom_range(0, 2));
  endtask

  task automatic test_cancel();
    bit bad;
    sel2 = 1'b0;
    @(negedge clk);
    id_alu_control = '0; id_alu_src1 = 32'h12345; id_alu_src2 = 32'h777; id_mult_op = 2'b01;
    id_rf_wdest = '0; mem_allowin = 1'b1; id_valid = 1'b1;
    @(posedge clk);
    #1 id_valid = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (over1 !== 1'b0 || allowin1 !== 1'b0) begin
      errors++; $display("FAIL cancel_busy: got over=%b allowin=%b expected 0 0", over1, allowin1);
    end
    cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    @(negedge clk);
    checks++;
    if (over1 !== 1'b0 || allowin1 !== 1'b1) begin
      errors++; $display("FAIL cancel_clear: got over=%b allowin=%b expected 0 1", over1, allowin1);
    end
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (we1 !== 1'b0 || over1 !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || hi1 !== exp_hi1 || lo1 !== exp_lo1) begin
      errors++; $display("FAIL cancel_no_we: got stray=%b hi=%h lo=%h expected 0 %h %h", bad, hi1, lo1, exp_hi1, exp_lo1);
    end
    id_alu_control = 13'h0800; id_mult_op = 2'b00; id_rf_wdest = 5'd6;
    id_valid = 1'b1; cancel = 1'b1;
    @(posedge clk);
    #1 id_valid = 1'b0; cancel = 1'b0;
    @(negedge clk);
    checks++;
    if (over1 !== 1'b0 || allowin1 !== 1'b1) begin
      errors++; $display("FAIL cancel_drop: got over=%b allowin=%b expected 0 1", over1, allowin1);
    end
    run_op("add_after_cancel", 0, 13'h0800, 32'd100, 32'd23, 2'b00, 5'd11, 0);
  endtask

  task automatic test_back_to_back();
    sel2 = 1'b0;
    @(negedge clk);
    mem_allowin = 1'b1; id_mult_op = 2'b00; id_rf_wdest = 5'd2;
    id_alu_control = 13'h0200; id_alu_src1 = 32'hFFFFFFFF; id_alu_src2 = 32'h1; id_valid = 1'b1;
    @(posedge clk);
    #1 id_alu_control = 13'h0100; id_rf_wdest = 5'd3;
    @(negedge clk);
    checks++;
    if (over1 !== 1'b1 || result1 !== 32'd1 || wd1 !== 5'd2 || allowin1 !== 1'b1) begin
      errors++; $display("FAIL b2b_slt: got over=%b res=%h wd=%0d expected 1 00000001 2", over1, result1, wd1);
    end
    @(posedge clk);
    #1 id_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (over1 !== 1'b1 || result1 !== 32'd0 || wd1 !== 5'd3) begin
      errors++; $display("FAIL b2b_sltu: got over=%b res=%h wd=%0d expected 1 00000000 3", over1, result1, wd1);
    end
    @(negedge clk);
    checks++;
    if (over1 !== 1'b0) begin errors++; $display("FAIL b2b_drain: got over=%b expected 0", over1); end
  endtask

  initial begin
    test_reset();
    test_alu_directed();
    test_alu_random();
    test_mult();
    test_mult_2bits();
    test_cancel();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
